// File: rtl/mk_top_pkg.sv
// Shared constants for the mk_top RV32I core: opcodes, funct fields, FSM states,
// request field layout and small load/store data helpers.
package mk_top_pkg;

    localparam int RQ_W        = 65;
    localparam int RQ_ADDR_LSB = 33;
    localparam int RQ_WR_BIT   = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH_RQ, S_FETCH_RS, S_EXEC, S_MEM_RQ, S_MEM_RS, S_WR_RQ, S_WR_RS, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
    } alu_op_e;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            F3_B:    return {{24{w[7]}}, w[7:0]};
            F3_H:    return {{16{w[15]}}, w[15:0]};
            F3_BU:   return {24'h0, w[7:0]};
            F3_HU:   return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Sub-word stores are read-modify-write: keep the untouched high bits of the old word.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] old,
                                                input logic [31:0] src);
        case (f3)
            F3_B:    return {old[31:8], src[7:0]};
            F3_H:    return {old[31:16], src[15:0]};
            default: return src;
        endcase
    endfunction

endpackage

// File: rtl/mk_top_alu.sv
// Combinational ALU and branch comparator for mk_top.
// Multiply ops are only implemented when MK_TOP_MUL_EN is defined.
module mk_top_alu
    import mk_top_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  br_f3,
    output logic [31:0] y,
    output logic        taken
);

`ifdef MK_TOP_MUL_EN
    // One 64-bit product serves all four variants; the op picks operand signedness.
    logic        sa, sb;
    logic [63:0] ma, mb, prod;
    assign sa   = (alu_op_e'(op) == ALU_MULH) || (alu_op_e'(op) == ALU_MULHSU);
    assign sb   = (alu_op_e'(op) == ALU_MULH);
    assign ma   = {{32{sa & a[31]}}, a};
    assign mb   = {{32{sb & b[31]}}, b};
    assign prod = ma * mb;
`endif

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'b0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
`ifdef MK_TOP_MUL_EN
            ALU_MUL:    y = prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  y = prod[63:32];
`endif
            default:    y = '0;
        endcase
    end

    always_comb begin
        case (br_f3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) <  $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a <  b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mk_top.sv
// Multi-cycle RV32I core with a single-outstanding request/response memory port.
// Define MK_TOP_MUL_EN to execute MUL/MULH/MULHSU/MULHU instead of halting on them.
module mk_top
    import mk_top_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN_obtain_rq_get,
    output logic [64:0] obtain_rq_get,
    output logic        RDY_obtain_rq_get,
    input  logic [31:0] send_rs_put,
    input  logic        EN_send_rs_put,
    output logic        RDY_send_rs_put
);

    state_e      state, state_nx;
    logic [31:0] pc, ir, maddr, wdata;
    logic [31:0] regs [32];

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1v, rs2v, eff;

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign f7    = ir[31:25];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    // regs[0] is never written, so x0 reads as zero without a mux.
    assign rs1v  = regs[rs1];
    assign rs2v  = regs[rs2];
    assign eff   = rs1v + ((opc == OP_STORE) ? imm_s : imm_i);

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_y, wb_val, pc_nx;
    logic        br_taken, illegal, wb_en;

    mk_top_alu u_alu (
        .op    (alu_op),
        .a     (rs1v),
        .b     (alu_b),
        .br_f3 (f3),
        .y     (alu_y),
        .taken (br_taken)
    );

    always_comb begin
        illegal = 1'b0;
        wb_en   = 1'b0;
        wb_val  = alu_y;
        pc_nx   = pc + 32'd4;
        alu_op  = ALU_ADD;
        alu_b   = imm_i;
        case (opc)
            OP_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_nx = pc + imm_j; end
            OP_JALR: begin
                illegal = (f3 != 3'd0);
                wb_en   = 1'b1;
                wb_val  = pc + 32'd4;
                pc_nx   = (rs1v + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                illegal = (f3 == 3'd2) || (f3 == 3'd3);
                alu_b   = rs2v;
                if (br_taken) pc_nx = pc + imm_b;
            end
            OP_LOAD:   illegal = (f3 == 3'd3) || (f3 >= 3'd6);
            OP_STORE:  illegal = (f3 > F3_W);
            OP_IMM: begin
                wb_en   = 1'b1;
                alu_op  = alu_decode(f3, (f3 == 3'd5) && f7[5]);
                illegal = ((f3 == 3'd1) && (f7 != F7_BASE)) ||
                          ((f3 == 3'd5) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OP_OP: begin
                wb_en = 1'b1;
                alu_b = rs2v;
                if (f7 == F7_MULDIV) begin
`ifdef MK_TOP_MUL_EN
                    illegal = f3[2];
                    case (f3[1:0])
                        2'd0:    alu_op = ALU_MUL;
                        2'd1:    alu_op = ALU_MULH;
                        2'd2:    alu_op = ALU_MULHSU;
                        default: alu_op = ALU_MULHU;
                    endcase
`else
                    illegal = 1'b1;
`endif
                end else begin
                    alu_op  = alu_decode(f3, f7[5]);
                    illegal = !((f7 == F7_BASE) ||
                                ((f7 == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5))));
                end
            end
            default:   illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_FETCH_RQ;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH_RQ: if (EN_obtain_rq_get) state_nx = S_FETCH_RS;
            S_FETCH_RS: if (EN_send_rs_put)   state_nx = S_EXEC;
            S_EXEC: begin
                if (illegal)               state_nx = S_HALT;
                else if (opc == OP_LOAD)   state_nx = S_MEM_RQ;
                else if (opc == OP_STORE)  state_nx = (f3 == F3_W) ? S_WR_RQ : S_MEM_RQ;
                else                       state_nx = S_FETCH_RQ;
            end
            S_MEM_RQ:   if (EN_obtain_rq_get) state_nx = S_MEM_RS;
            S_MEM_RS:   if (EN_send_rs_put)   state_nx = (opc == OP_STORE) ? S_WR_RQ : S_FETCH_RQ;
            S_WR_RQ:    if (EN_obtain_rq_get) state_nx = S_WR_RS;
            S_WR_RS:    if (EN_send_rs_put)   state_nx = S_FETCH_RQ;
            default:    state_nx = S_HALT;
        endcase
    end

    always_comb begin
        RDY_obtain_rq_get = 1'b0;
        RDY_send_rs_put   = 1'b0;
        obtain_rq_get     = '0;
        case (state)
            S_FETCH_RQ: begin
                RDY_obtain_rq_get = 1'b1;
                obtain_rq_get[RQ_ADDR_LSB +: 32] = pc;
            end
            S_MEM_RQ: begin
                RDY_obtain_rq_get = 1'b1;
                obtain_rq_get[RQ_ADDR_LSB +: 32] = maddr;
            end
            S_WR_RQ: begin
                RDY_obtain_rq_get = 1'b1;
                obtain_rq_get[RQ_ADDR_LSB +: 32] = maddr;
                obtain_rq_get[RQ_WR_BIT]          = 1'b1;
                obtain_rq_get[31:0]               = wdata;
            end
            S_FETCH_RS, S_MEM_RS, S_WR_RS: RDY_send_rs_put = 1'b1;
            default: ;
        endcase
        // Handshakes stay closed for as long as reset is held.
        if (RST) begin
            RDY_obtain_rq_get = 1'b0;
            RDY_send_rs_put   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc    <= RESET_PC;
            ir    <= '0;
            maddr <= '0;
            wdata <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH_RS: if (EN_send_rs_put) ir <= send_rs_put;
                S_EXEC: if (!illegal) begin
                    pc    <= pc_nx;
                    maddr <= eff;
                    wdata <= rs2v;
                    if (wb_en && (rd != 5'd0)) regs[rd] <= wb_val;
                end
                S_MEM_RS: if (EN_send_rs_put) begin
                    if (opc == OP_LOAD) begin
                        if (rd != 5'd0) regs[rd] <= load_ext(f3, send_rs_put);
                    end else begin
                        wdata <= store_merge(f3, send_rs_put, rs2v);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mk_top.sv
// Scoreboard bench for mk_top: a word-addressed memory model answers requests,
// and every presented request is checked against an expected-request queue.
module tb_mk_top;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN_obtain_rq_get = 1'b0;
    logic        EN_send_rs_put = 1'b0;
    logic [31:0] send_rs_put = '0;
    logic [64:0] obtain_rq_get;
    logic        RDY_obtain_rq_get, RDY_send_rs_put;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem [logic [31:0]];
    logic [64:0] exp_q [$];

    logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF85, 32'h0000_0085, 32'hFFFF_FF85,
                                32'h0000_FF85, 32'hFFFF_FF85};
    logic [11:0] st_imm [2] = '{12'h0AB, 12'hFFE};
    logic [2:0]  st_f3  [2] = '{3'd0, 3'd1};
    logic [31:0] st_exp [2] = '{32'h1122_33AB, 32'h1122_FFFE};

    always #5 CLK = ~CLK;

    mk_top dut (
        .CLK               (CLK),
        .RST               (RST),
        .EN_obtain_rq_get  (EN_obtain_rq_get),
        .obtain_rq_get     (obtain_rq_get),
        .RDY_obtain_rq_get (RDY_obtain_rq_get),
        .send_rs_put       (send_rs_put),
        .EN_send_rs_put    (EN_send_rs_put),
        .RDY_send_rs_put   (RDY_send_rs_put)
    );

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] rq(input logic [31:0] a, input logic w, input logic [31:0] d);
        return {a, w, d};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic clear();
        mem.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        EN_obtain_rq_get = 1'b0;
        EN_send_rs_put = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_rdy_rq", RDY_obtain_rq_get, 0);
        chk("rst_rdy_rs", RDY_send_rs_put, 0);
        @(negedge CLK);
        RST = 1'b0;
        EN_obtain_rq_get = 1'b1;
        #1;
    endtask

    // Consumer holds EN_obtain high; responses come `delay` cycles after each transfer.
    task automatic run(input string name, input int delay, input bit stop_empty,
                       input bit halt_end, input int budget);
        bit          pend, stop;
        int          wait_c, idle, n_obs, n_exp;
        logic [64:0] cur;
        pend = 0; stop = 0; wait_c = 0; idle = 0; n_obs = 0; cur = '0;
        n_exp = exp_q.size();
        for (int c = 0; c < budget && !stop && idle < 20; c++) begin
            EN_send_rs_put = 1'b0;
            if (pend) begin
                chk({name, "_no_rq_while_pend"}, RDY_obtain_rq_get, 0);
                chk({name, "_rdy_rs"}, RDY_send_rs_put, 1);
                wait_c++;
                if (wait_c >= delay) begin
                    if (cur[32]) begin
                        mem[cur[64:33]] = cur[31:0];
                        send_rs_put = $urandom;
                    end else begin
                        send_rs_put = mem.exists(cur[64:33]) ? mem[cur[64:33]] : 32'h0;
                    end
                    EN_send_rs_put = 1'b1;
                    pend = 0;
                end
            end else if (RDY_obtain_rq_get) begin
                idle = 0;
                if (exp_q.size() != 0) chk({name, "_rq"}, obtain_rq_get, exp_q.pop_front());
                n_obs++;
                cur = obtain_rq_get;
                pend = 1;
                wait_c = 0;
                if (stop_empty && n_obs == n_exp) stop = 1;
            end else begin
                idle++;
            end
            @(negedge CLK);
            #1;
        end
        EN_send_rs_put = 1'b0;
        chk({name, "_rq_count"}, n_obs, n_exp);
        if (halt_end) begin
            chk({name, "_halt_rdy_rq"}, RDY_obtain_rq_get, 0);
            chk({name, "_halt_rdy_rs"}, RDY_send_rs_put, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ADDI then SW: first fetch at reset PC, store carries 5
        clear();
        mem[32'h0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[32'h4] = enc_s(12'h100, 5'd1, 5'd0, 3'd2);
        exp_q = '{rq(0, 0, 0), rq(4, 0, 0), rq(32'h100, 1, 5), rq(8, 0, 0)};
        do_reset();
        run("addi_sw", 1, 0, 1, 300);

        // load width/sign variants of word 0xFFFFFF85, observed through SW
        for (int k = 0; k < 5; k++) begin
            clear();
            mem[32'h80] = 32'hFFFF_FF85;
            mem[32'h0]  = enc_i(12'h080, 5'd0, ld_f3[k], 5'd2, 7'h03);
            mem[32'h4]  = enc_s(12'h104, 5'd2, 5'd0, 3'd2);
            exp_q = '{rq(0, 0, 0), rq(32'h80, 0, 0), rq(4, 0, 0),
                      rq(32'h104, 1, ld_exp[k]), rq(8, 0, 0)};
            do_reset();
            run("load", 1 + k, 0, 1, 300);
        end

        // SB / SH read-modify-write
        for (int k = 0; k < 2; k++) begin
            clear();
            mem[32'h200] = 32'h1122_3344;
            mem[32'h0]   = enc_i(st_imm[k], 5'd0, 3'd0, 5'd3, 7'h13);
            mem[32'h4]   = enc_s(12'h200, 5'd3, 5'd0, st_f3[k]);
            exp_q = '{rq(0, 0, 0), rq(4, 0, 0), rq(32'h200, 0, 0),
                      rq(32'h200, 1, st_exp[k]), rq(8, 0, 0)};
            do_reset();
            run("subword_st", 2, 0, 1, 300);
        end

        // LUI, SRAI, JAL link/target, x0 write discard, SUB
        clear();
        mem[32'h00] = {20'h80000, 5'd1, 7'h37};
        mem[32'h04] = enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13);
        mem[32'h08] = enc_s(12'h100, 5'd2, 5'd0, 3'd2);
        mem[32'h0C] = enc_j(21'd8, 5'd5);
        mem[32'h14] = enc_s(12'h104, 5'd5, 5'd0, 3'd2);
        mem[32'h18] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
        mem[32'h1C] = enc_s(12'h108, 5'd0, 5'd0, 3'd2);
        mem[32'h20] = enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd6);
        mem[32'h24] = enc_s(12'h10C, 5'd6, 5'd0, 3'd2);
        exp_q = '{rq(0, 0, 0), rq(4, 0, 0), rq(8, 0, 0), rq(32'h100, 1, 32'hF800_0000),
                  rq(32'h0C, 0, 0), rq(32'h14, 0, 0), rq(32'h104, 1, 32'h10),
                  rq(32'h18, 0, 0), rq(32'h1C, 0, 0), rq(32'h108, 1, 0),
                  rq(32'h20, 0, 0), rq(32'h24, 0, 0), rq(32'h10C, 1, 32'h0800_0000),
                  rq(32'h28, 0, 0)};
        do_reset();
        run("alu_jal", 1, 0, 1, 500);

        // BEQ x0,x0,0 self-loop with slow responses; left mid-transaction on exit
        clear();
        mem[32'h0] = enc_b(13'd0, 5'd0, 5'd0, 3'd0);
        exp_q = '{rq(0, 0, 0), rq(0, 0, 0), rq(0, 0, 0), rq(0, 0, 0)};
        do_reset();
        run("beq_loop", 5, 1, 0, 300);

        // all-zero encoding halts right after its fetch
        clear();
        exp_q = '{rq(0, 0, 0)};
        do_reset();
        run("halt", 1, 0, 1, 100);

        // MUL 6*7
        clear();
        mem[32'h0] = enc_i(12'd6, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[32'h4] = enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13);
        mem[32'h8] = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
        mem[32'hC] = enc_s(12'h100, 5'd3, 5'd0, 3'd2);
`ifdef MK_TOP_MUL_EN
        exp_q = '{rq(0, 0, 0), rq(4, 0, 0), rq(8, 0, 0), rq(32'hC, 0, 0),
                  rq(32'h100, 1, 42), rq(32'h10, 0, 0)};
`else
        exp_q = '{rq(0, 0, 0), rq(4, 0, 0), rq(8, 0, 0)};
`endif
        do_reset();
        run("mul", 1, 0, 1, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mk_top.md
MK_TOP -- requirements
Module: mk_top

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  one clock; reset is asynchronous and active-high.
REQ-004 EN_obtain_rq_get  in  1  consumer takes the pending memory request this cycle.
REQ-005 obtain_rq_get  out  65  request: [64:33] byte address, [32] iswrite, [31:0] write data.
REQ-006 RDY_obtain_rq_get  out  1  a request is pending on obtain_rq_get.
REQ-007 send_rs_put  in  32  response data (read word at request address).
REQ-008 EN_send_rs_put  in  1  response valid this cycle.
REQ-009 RDY_send_rs_put  out  1  core is waiting for a response.

Function
REQ-010 mk_top SHALL be a multi-cycle RV32I core (all RV32I base integer ops, loads, stores, branches, JAL/JALR, LUI/AUIPC); FENCE/ECALL/EBREAK and any unsupported encoding SHALL enter HALT.
REQ-011 States: FETCH_RQ -> FETCH_RS -> EXEC -> (MEM_RQ -> MEM_RS [-> WR_RQ -> WR_RS]) -> FETCH_RQ; HALT is terminal until reset.
REQ-012 Exactly one outstanding request; every request, read or write, receives exactly one response before the next request is presented.
REQ-013 RDY_obtain_rq_get high only in FETCH_RQ/MEM_RQ/WR_RQ; obtain_rq_get stable while RDY high; transfer occurs in the cycle RDY and EN are both high; EN without RDY ignored.
REQ-014 RDY_send_rs_put high only in FETCH_RS/MEM_RS/WR_RS; response accepted when RDY and EN both high; EN without RDY ignored; write responses' data discarded.
REQ-015 Response may arrive any cycle after the request transfer (minimum 1 cycle later); core waits indefinitely.
REQ-016 Read requests SHALL drive iswrite=0 and data=0.
REQ-017 Memory is word-granular at arbitrary byte address: LW/LH/LHU/LB/LBU read the word at the effective address and use bits [31:0]/[15:0]/[7:0] with sign/zero extension.
REQ-018 SW issues one write; SB/SH SHALL read the word at the effective address, merge the low byte/halfword of rs2 into bits [7:0]/[15:0], then write the merged word back.
REQ-019 x0 reads zero; writes to x0 discarded; all arithmetic modulo 2^32; shifts use rs2[4:0].
REQ-020 PC advances by 4 in EXEC, or to branch/jump target (JALR target bit 0 cleared); no alignment checks.
REQ-021 EXEC completes in one cycle; register writeback for loads occurs on the MEM_RS response cycle.
REQ-022 HALT: RDY_obtain_rq_get=0, RDY_send_rs_put=0, PC and registers frozen.

Reset
REQ-023 While RST high: state=FETCH_RQ, PC=RESET_PC, x1..x31=0, both RDY outputs 0.
REQ-024 RST asserted mid-transaction SHALL abandon it; first cycle after deassertion presents fetch at RESET_PC (RDY_obtain_rq_get=1, obtain_rq_get={RESET_PC,1'b0,32'h0}).

Configuration
REQ-025 Macro MK_TOP_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU (funct7=0000001) execute in one EXEC cycle; when undefined, those encodings enter HALT; DIV/REM always HALT.

Structure
REQ-026 Package mk_top_pkg SHALL hold opcode/funct constants, state enumeration, and the 65-bit request field offsets.
REQ-027 One sub-module mk_top_alu (combinational ALU and branch compare); register file and FSM remain in mk_top.

Verification
REQ-028 Reset then release, EN_obtain held high -> first request addr 0, iswrite 0, data 0; RDY_send_rs_put high next cycle.
REQ-029 Program ADDI x1,x0,5; SW x1,0x100(x0) with 1-cycle response memory -> write request addr 0x100, iswrite 1, data 5.
REQ-030 Memory word 0x80 = 0xFFFFFF85; LB x2,0x80(x0); SW x2,0x104(x0) -> write data 0xFFFFFF85; LBU variant -> 0x00000085.
REQ-031 Word at 0x200 = 0x11223344; SB of rs2=0xAB to 0x200 -> read at 0x200 then write 0x112233AB.
REQ-032 BEQ x0,x0,-0 loop -> fetch address repeats at branch PC; response delayed 5 cycles -> no new request until response accepted.
REQ-033 Encoding 0x00000000 -> HALT, no further RDY_obtain_rq_get; MUL x3=6*7 -> 42 with MK_TOP_MUL_EN, HALT without.
